// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel UART receiver with a 2-flop input synchronizer.
// Latency: byte strobed one cycle after the stop-bit centre sample (about 9.5 bit times after the start edge).
// Backpressure: none; the consumer must take Data on the single-cycle Valid strobe.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.

module uart_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  output logic [7:0] Data,
  output logic       Valid,
  output logic       FrameErr,
  output logic       ParityErr,
  output logic       Busy
);

  // Sample points: the start bit is checked half a bit in, then every full
  // bit period after that, so data/stop bits are read at their centres.
  localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        parity_err_q, parity_err_d;
  logic        busy_q, busy_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
`endif

  // Next-state logic: synchronizer, baud timer, bit assembly and strobes.
  always_comb begin
    rx_meta_d    = Rx;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    timer_d      = timer_q + 16'd1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Timer parked at zero so START begins counting from a clean origin.
        timer_d   = 16'd0;
        bit_idx_d = 3'd0;
        if (!rx_s_q) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (timer_q == HALF_M1) begin
          timer_d = 16'd0;
          // A line that is high again at mid start bit was only a glitch.
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (timer_q == BIT_M1) begin
          timer_d           = 16'd0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d         = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (timer_q == BIT_M1) begin
          timer_d = 16'd0;
          par_d   = rx_s_q;
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (timer_q == BIT_M1) begin
          timer_d = 16'd0;
          if (rx_s_q) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must hold an even count of ones.
            if (par_q != (^shift_q)) begin
              parity_err_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            // Framing error wins over any parity result; Data is left alone.
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        // Hold here while the line stays low so a break cannot look like a new start bit.
        timer_d = 16'd0;
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        timer_d = 16'd0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      timer_q      <= 16'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign Data      = data_q;
  assign Valid     = valid_q;
  assign FrameErr  = frame_err_q;
  assign ParityErr = parity_err_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at CLKS_PER_BIT=16.
// Frames are driven bit by bit on the serial line; outcomes are predicted from the frame contents.
// Honours UART_RX_PARITY_EN for frame layout and the parity scenario.

module tb_uart_receiver;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       Rx;
  logic [7:0] Data;
  logic       Valid, FrameErr, ParityErr, Busy;

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .Rx(Rx), .Data(Data), .Valid(Valid),
    .FrameErr(FrameErr), .ParityErr(ParityErr), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed strobe events: {kind, Data}; kind 1=Valid, 2=FrameErr, 3=ParityErr.
  logic [9:0] ev_q[$];
  int   multi_cnt   = 0;
  int   busy_late   = 0;
  int   parity_seen = 0;
  logic prev_ok     = 1'b0;
  logic [7:0] exp_data;

  always @(negedge clk) begin
    if ((int'(Valid) + int'(FrameErr) + int'(ParityErr)) > 1) multi_cnt++;
    if (Valid)     ev_q.push_back({2'd1, Data});
    if (FrameErr)  ev_q.push_back({2'd2, Data});
    if (ParityErr) begin
      ev_q.push_back({2'd3, Data});
      parity_seen++;
    end
    if (prev_ok && Busy) busy_late++;
    prev_ok = Valid | ParityErr;
  end

  function automatic logic [9:0] ev_at(int i);
    return (ev_q.size() > i) ? ev_q[i] : 10'h3FF;
  endfunction

  // Drive one frame: start, 8 data bits LSB first, optional parity, stop; line idles high after.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    Rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i];
      repeat (C) @(negedge clk);
    end
    if (PAR_EN) begin
      Rx = par_bit;
      repeat (C) @(negedge clk);
    end
    Rx = stop_bit;
    repeat (C) @(negedge clk);
    Rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    Rx  = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (Data !== 8'h00)    begin n_bad++; $display("FAIL reset_data: got %h want 00", Data); end
    n_cmp++; if (Valid !== 1'b0)    begin n_bad++; $display("FAIL reset_valid: got %b want 0", Valid); end
    n_cmp++; if (FrameErr !== 1'b0) begin n_bad++; $display("FAIL reset_frameerr: got %b want 0", FrameErr); end
    n_cmp++; if (ParityErr !== 1'b0) begin n_bad++; $display("FAIL reset_parityerr: got %b want 0", ParityErr); end
    n_cmp++; if (Busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (Busy !== 1'b0)     begin n_bad++; $display("FAIL idle_busy: got %b want 0", Busy); end
    exp_data = 8'h00;
  endtask

  task automatic test_basic();
    ev_q.delete();
    fork
      send_frame(8'h55, 1'b1, ^8'h55);
      begin
        repeat (3 * C) @(negedge clk);
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_mid: got %b want 1", Busy); end
      end
    join
    repeat (4) @(negedge clk);
    exp_data = 8'h55;
    n_cmp++; if (ev_q.size() != 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", ev_q.size()); end
    n_cmp++; if (ev_at(0) !== {2'd1, 8'h55}) begin n_bad++; $display("FAIL basic_event: got %h want %h", ev_at(0), {2'd1, 8'h55}); end
    n_cmp++; if (Data !== 8'h55) begin n_bad++; $display("FAIL basic_data: got %h want 55", Data); end
    n_cmp++; if (Busy !== 1'b0)  begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", Busy); end
  endtask

  task automatic test_back_to_back();
    ev_q.delete();
    send_frame(8'hA3, 1'b1, ^8'hA3);
    n_cmp++; if (Data !== 8'hA3) begin n_bad++; $display("FAIL b2b_first_data: got %h want a3", Data); end
    send_frame(8'h3C, 1'b1, ^8'h3C);
    repeat (4) @(negedge clk);
    exp_data = 8'h3C;
    n_cmp++; if (ev_q.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", ev_q.size()); end
    n_cmp++; if (ev_at(0) !== {2'd1, 8'hA3}) begin n_bad++; $display("FAIL b2b_ev0: got %h want %h", ev_at(0), {2'd1, 8'hA3}); end
    n_cmp++; if (ev_at(1) !== {2'd1, 8'h3C}) begin n_bad++; $display("FAIL b2b_ev1: got %h want %h", ev_at(1), {2'd1, 8'h3C}); end
  endtask

  task automatic test_glitch();
    int busy_cyc;
    busy_cyc = 0;
    ev_q.delete();
    Rx = 1'b0;
    repeat (3) begin @(negedge clk); busy_cyc += int'(Busy); end
    Rx = 1'b1;
    repeat (30) begin @(negedge clk); busy_cyc += int'(Busy); end
    n_cmp++; if (busy_cyc < 1 || busy_cyc > 8) begin n_bad++; $display("FAIL glitch_busy_cycles: got %0d want 1..8", busy_cyc); end
    n_cmp++; if (ev_q.size() != 0) begin n_bad++; $display("FAIL glitch_strobes: got %0d want 0", ev_q.size()); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_end: got %b want 0", Busy); end
  endtask

  task automatic test_break();
    ev_q.delete();
    send_frame(8'hF0, 1'b0, ^8'hF0);
    Rx = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (ev_q.size() != 1) begin n_bad++; $display("FAIL break_count: got %0d want 1", ev_q.size()); end
    n_cmp++; if (ev_at(0) !== {2'd2, exp_data}) begin n_bad++; $display("FAIL break_event: got %h want %h", ev_at(0), {2'd2, exp_data}); end
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL break_busy_held: got %b want 1", Busy); end
    Rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    n_cmp++; if (ev_q.size() != 1) begin n_bad++; $display("FAIL break_retrigger: got %0d want 1", ev_q.size()); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL break_busy_release: got %b want 0", Busy); end
    n_cmp++; if (Data !== exp_data) begin n_bad++; $display("FAIL break_data: got %h want %h", Data, exp_data); end
  endtask

  task automatic test_reset_mid();
    ev_q.delete();
    fork
      send_frame(8'hF1, 1'b1, ^8'hF1);
      begin
        repeat (5 * C + C / 2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (Data !== 8'h00)     begin n_bad++; $display("FAIL rmid_data: got %h want 00", Data); end
        n_cmp++; if (Busy !== 1'b0)      begin n_bad++; $display("FAIL rmid_busy: got %b want 0", Busy); end
        n_cmp++; if (Valid !== 1'b0)     begin n_bad++; $display("FAIL rmid_valid: got %b want 0", Valid); end
        n_cmp++; if (FrameErr !== 1'b0)  begin n_bad++; $display("FAIL rmid_frameerr: got %b want 0", FrameErr); end
        rst = 1'b1;
      end
    join
    exp_data = 8'h00;
    repeat (4) @(negedge clk);
    n_cmp++; if (ev_q.size() != 0) begin n_bad++; $display("FAIL rmid_discard: got %0d want 0", ev_q.size()); end
    send_frame(8'h81, 1'b1, ^8'h81);
    repeat (4) @(negedge clk);
    exp_data = 8'h81;
    n_cmp++; if (ev_at(0) !== {2'd1, 8'h81}) begin n_bad++; $display("FAIL rmid_next: got %h want %h", ev_at(0), {2'd1, 8'h81}); end
    n_cmp++; if (Data !== 8'h81) begin n_bad++; $display("FAIL rmid_next_data: got %h want 81", Data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    ev_q.delete();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (ev_at(0) !== {2'd3, exp_data}) begin n_bad++; $display("FAIL parity_bad: got %h want %h", ev_at(0), {2'd3, exp_data}); end
    n_cmp++; if (ev_q.size() != 1) begin n_bad++; $display("FAIL parity_bad_count: got %0d want 1", ev_q.size()); end
    ev_q.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    exp_data = 8'h07;
    n_cmp++; if (ev_at(0) !== {2'd1, 8'h07}) begin n_bad++; $display("FAIL parity_good: got %h want %h", ev_at(0), {2'd1, 8'h07}); end
    n_cmp++; if (Data !== 8'h07) begin n_bad++; $display("FAIL parity_good_data: got %h want 07", Data); end
  endtask
`else
  task automatic test_parity_tied();
    n_cmp++; if (parity_seen != 0) begin n_bad++; $display("FAIL parity_tied: got %0d pulses want 0", parity_seen); end
    n_cmp++; if (ParityErr !== 1'b0) begin n_bad++; $display("FAIL parity_tied_now: got %b want 0", ParityErr); end
  endtask
`endif

  // Random frames: good, bad stop, and (with parity) bad parity, with random idle gaps.
  task automatic test_random();
    logic [7:0] d;
    logic       stop_b, par_b;
    logic [9:0] exp_ev;
    int         gap;
    for (int n = 0; n < 24; n++) begin
      d      = 8'($urandom);
      stop_b = ($urandom % 5) != 0;
      par_b  = (($urandom % 4) == 0) ? ~(^d) : (^d);
      ev_q.delete();
      send_frame(d, stop_b, par_b);
      if (!stop_b) begin
        exp_ev = {2'd2, exp_data};
      end else if (PAR_EN && (par_b != (^d))) begin
        exp_ev = {2'd3, exp_data};
      end else begin
        exp_data = d;
        exp_ev   = {2'd1, d};
      end
      n_cmp++; if (ev_q.size() != 1) begin n_bad++; $display("FAIL rand_count[%0d]: got %0d want 1", n, ev_q.size()); end
      n_cmp++; if (ev_at(0) !== exp_ev) begin n_bad++; $display("FAIL rand_event[%0d]: got %h want %h", n, ev_at(0), exp_ev); end
      n_cmp++; if (Data !== exp_data) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, Data, exp_data); end
      gap = stop_b ? int'($urandom % 3) : 2 + int'($urandom % 4);
      repeat (gap) @(negedge clk);
    end
    repeat (3 * C) @(negedge clk);
  endtask

  task automatic test_strobes();
    n_cmp++; if (multi_cnt != 0) begin n_bad++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", multi_cnt); end
    n_cmp++; if (busy_late != 0) begin n_bad++; $display("FAIL busy_after_strobe: got %0d cycles want 0", busy_late); end
  endtask

  initial begin
    rst = 1'b0;
    Rx  = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_parity_tied();
`endif
    test_random();
    test_strobes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver: the receive end of the team's 8-bit UART link, matching the transmitter's frame (start bit, 8 data bits LSB first, stop bit). It synchronizes the asynchronous `Rx` line, times each bit with an internal baud counter, samples at bit centres and presents each received byte with a one-cycle valid strobe. It sits between the board RX pin and the byte consumer (FIFO or control logic).

## Interface
- `CLKS_PER_BIT`, default 868, clock cycles per bit period (100 MHz / 115200 baud); legal range 4 to 65535.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `Rx`  input  1  asynchronous serial line; idle high.
- `Data`  output  8  last correctly framed byte; holds until the next good frame.
- `Valid`  output  1  one-cycle strobe: `Data` was updated this cycle.
- `FrameErr`  output  1  one-cycle strobe: stop bit sampled low.
- `ParityErr`  output  1  one-cycle strobe: parity mismatch (macro builds only; constant 0 otherwise).
- `Busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- `Rx` passes through a 2-flop synchronizer (`rx_s`); reset loads both flops with 1.
- Baud timer: 16-bit counter, cleared on every state entry and after every sample point.
- States:
  - IDLE: `Busy`=0. When `rx_s`=0, go to START and clear the timer.
  - START: at timer = CLKS_PER_BIT/2 − 1 (integer division), sample `rx_s`. If 0, go to DATA with bit index 0. If 1 (glitch), return to IDLE with no strobe.
  - DATA: at timer = CLKS_PER_BIT − 1, shift `rx_s` into the shift register at bit [index], LSB first. After index 7, go to STOP (or to PARITY with the macro).
  - STOP: at timer = CLKS_PER_BIT − 1, sample `rx_s`.
    - If 1: load `Data` from the shift register, pulse `Valid`, go to IDLE.
    - If 0: pulse `FrameErr`, leave `Data` unchanged, go to BREAK.
  - BREAK: wait until `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- Strobes are registered, high for exactly one cycle, and mutually exclusive.
- Reset (`rst`=0 at a clock edge), from any state and mid-frame:
  - FSM returns to IDLE; timer and bit index clear.
  - `Data`=8'h00, `Valid`=0, `FrameErr`=0, `ParityErr`=0, `Busy`=0.
  - A partially received frame is discarded.

## Timing
- Synchronizer latency: 2 cycles from an `Rx` edge to `rx_s`.
- Sample points, measured from the first cycle in START (S = CLKS_PER_BIT/2):
  - start bit at S cycles;
  - data bit k (k = 0..7) at S + (k+1)·CLKS_PER_BIT;
  - stop bit at S + 9·CLKS_PER_BIT, or S + 10·CLKS_PER_BIT with the macro.
- `Valid`/`FrameErr` rise in the cycle after the stop sample point.
- `Busy` rises in the cycle after START entry and falls with the return to IDLE.
- Back-to-back frames: a start edge arriving the cycle after the return to IDLE is accepted. No idle gap is needed beyond the stop bit.
- A low glitch shorter than S cycles never produces a strobe.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - adds a PARITY state between DATA and STOP that samples one even-parity bit at timer = CLKS_PER_BIT − 1;
  - on a good stop bit with a parity mismatch, pulse `ParityErr` instead of `Valid` and leave `Data` unchanged;
  - a framing error takes priority over a parity error; only `FrameErr` pulses.
- Undefined: 10-bit frame, no PARITY state, `ParityErr` tied to 0.

## Test plan
- CLKS_PER_BIT=16, send 8'h55 with a good stop bit -> `Valid` pulses once, `Data`=8'h55, `FrameErr`=0, `Busy` low one cycle after the strobe.
- Two back-to-back frames, 8'hA3 then 8'h3C, with no idle gap -> two `Valid` pulses, `Data`=8'hA3 then 8'h3C.
- 3-cycle low glitch on idle `Rx` (CLKS_PER_BIT=16) -> no strobe; FSM back in IDLE within 8 cycles of START entry.
- Send 8'hF0 with the stop bit low, hold `Rx` low 40 cycles, then release -> one `FrameErr` pulse, `Data` keeps its prior value, no retrigger until `Rx` returns high.
- Assert `rst`=0 for one cycle during data bit 4, then send 8'h81 -> all outputs at reset values after the edge; next frame yields `Data`=8'h81.
- With `UART_RX_PARITY_EN`, send 8'h07 with parity bit 0 (wrong) -> `ParityErr` pulses, no `Valid`; resend with parity 1 -> `Valid`, `Data`=8'h07.
